// File: rtl/bf_unit_modmul_pipe.sv
// bf_unit_modmul_pipe
// Pipelined unsigned W x W multiplier for the NTT butterfly lanes. It either
// returns the raw 2W-bit product or reduces it modulo Q with Barrett's method.
// Every register, including the valid and flag bits, advances only when ce=1.
// Latency is (REDUCE ? 4 : 1) + OUT_STAGES enabled edges, with one operation
// accepted per enabled cycle.

module bf_unit_modmul_pipe #(
    parameter int              W          = 32,
    parameter longint unsigned Q          = 64'd3221225473,
    parameter longint unsigned MU         = 64'd5726623059,
    parameter bit              REDUCE     = 1'b1,
    parameter int              OUT_STAGES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             in_valid,
    input  logic [W-1:0]     din0,
    input  logic [W-1:0]     din1,
    output logic             out_valid,
    output logic [2*W-1:0]   dout,
    output logic             range_err
);

    localparam int PW = 2 * W;

    // Stage 1: full product plus its valid bit
    logic          v1;
    logic [PW-1:0] x1;

    // Output of the arithmetic core, before the optional retiming stages
    logic          core_v;
    logic [PW-1:0] core_d;
    logic          core_e;

    // S1 register: capture the raw product and the valid bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1 <= 1'b0;
            x1 <= '0;
        end else if (ce) begin
            v1 <= in_valid;
            x1 <= PW'(din0) * PW'(din1);
        end
    end

    generate
        if (REDUCE) begin : g_reduce
            localparam logic [W-1:0] QW  = W'(Q);
            localparam logic [W+1:0] QR  = (W+2)'(Q);
            localparam logic [W:0]   MUW = (W+1)'(MU);

            logic          e1;
            logic [W:0]    t2;
            logic [PW-1:0] x2;
            logic          v2, e2;
            logic [W+1:0]  r3;
            logic          v3, e3;
            logic [W-1:0]  r4;
            logic          v4, e4;

            // Barrett quotient estimate: t never exceeds floor(x/Q), so the
            // remainder below is non-negative and stays under 3Q.
            logic [W:0]      q1;
            logic [2*W+1:0]  q2;
            logic [W:0]      t_est;
            logic [2*W:0]    tq;
            logic [W+1:0]    r_est;
            logic [W+1:0]    r_a;
            logic [W+1:0]    r_b;

            assign q1    = (W+1)'(x1 >> (W-1));
            assign q2    = (2*W+2)'(q1) * (2*W+2)'(MUW);
            assign t_est = (W+1)'(q2 >> (W+1));

            // Only the low W+2 bits of x - t*Q are meaningful; the difference
            // is computed modulo 2^(W+2) on purpose.
            assign tq    = (2*W+1)'(t2) * (2*W+1)'(QW);
            assign r_est = (W+2)'(x2) - (W+2)'(tq);

            // Two conditional subtractions bring r from [0, 3Q) into [0, Q)
            assign r_a = (r3 >= QR) ? (r3 - QR) : r3;
            assign r_b = (r_a >= QR) ? (r_a - QR) : r_a;

            // S1 side register: out-of-range flag for the operands
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    e1 <= 1'b0;
                end else if (ce) begin
                    e1 <= (din0 >= QW) | (din1 >= QW);
                end
            end

            // S2 register: quotient estimate, product carried forward
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    t2 <= '0;
                    x2 <= '0;
                    v2 <= 1'b0;
                    e2 <= 1'b0;
                end else if (ce) begin
                    t2 <= t_est;
                    x2 <= x1;
                    v2 <= v1;
                    e2 <= e1;
                end
            end

            // S3 register: partial remainder x - t*Q
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r3 <= '0;
                    v3 <= 1'b0;
                    e3 <= 1'b0;
                end else if (ce) begin
                    r3 <= r_est;
                    v3 <= v2;
                    e3 <= e2;
                end
            end

            // S4 register: fully reduced remainder
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r4 <= '0;
                    v4 <= 1'b0;
                    e4 <= 1'b0;
                end else if (ce) begin
                    r4 <= W'(r_b);
                    v4 <= v3;
                    e4 <= e3;
                end
            end

            assign core_v = v4;
            assign core_d = {{W{1'b0}}, r4};
            assign core_e = e4;
        end else begin : g_raw
            assign core_v = v1;
            assign core_d = x1;
            assign core_e = 1'b0;
        end
    endgenerate

    generate
        if (OUT_STAGES > 0) begin : g_out
            logic [OUT_STAGES-1:0] vs;
            logic [OUT_STAGES-1:0] es;
            logic [PW-1:0]         ds [OUT_STAGES];

            // Retiming shift register; valid, flag and data move in lockstep
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    vs <= '0;
                    es <= '0;
                    for (int i = 0; i < OUT_STAGES; i++) begin
                        ds[i] <= '0;
                    end
                end else if (ce) begin
                    vs[0] <= core_v;
                    es[0] <= core_e;
                    ds[0] <= core_d;
                    for (int i = 1; i < OUT_STAGES; i++) begin
                        vs[i] <= vs[i-1];
                        es[i] <= es[i-1];
                        ds[i] <= ds[i-1];
                    end
                end
            end

            assign out_valid = vs[OUT_STAGES-1];
            assign range_err = es[OUT_STAGES-1];
            assign dout      = ds[OUT_STAGES-1];
        end else begin : g_noout
            assign out_valid = core_v;
            assign range_err = core_e;
            assign dout      = core_d;
        end
    endgenerate

endmodule
